// File: rtl/alu_op_issue_stage_if.sv
// Handshake bundle between decode and the ALU op issue stage.
// master = the issue stage, slave = the surrounding pipeline.
interface alu_op_issue_stage_if #(
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [6:0]               in_opcode;
    logic [2:0]               in_funct3;
    logic                     in_funct7b5;
    logic [TAG_WIDTH-1:0]     in_tag;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPCODE_LENGTH-1:0] out_operation;
    logic                     out_alu_src_imm;
    logic                     out_illegal;
    logic [TAG_WIDTH-1:0]     out_tag;

    modport master (
        input  in_valid, in_opcode, in_funct3, in_funct7b5, in_tag,
        input  out_ready,
        output in_ready,
        output out_valid, out_operation, out_alu_src_imm, out_illegal,
        output out_tag
    );

    modport slave (
        output in_valid, in_opcode, in_funct3, in_funct7b5, in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid, out_operation, out_alu_src_imm, out_illegal,
        input  out_tag
    );
endinterface

// File: rtl/alu_op_issue_stage.sv
// Decodes opcode/funct3/funct7[5] into an ALU operation code and
// presents it through an output register backed by one skid entry.
module alu_op_issue_stage #(
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    alu_op_issue_stage_if.master io
);

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;

    localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR    = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ    = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL   = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_PASSB = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL   = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA   = OPCODE_LENGTH'(4'b1101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT   = OPCODE_LENGTH'(4'b1110);

    typedef struct packed {
        logic [OPCODE_LENGTH-1:0] op;
        logic                     imm;
        logic                     ill;
        logic [TAG_WIDTH-1:0]     tag;
    } entry_t;

    entry_t dec;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   advance;
    logic   is_i;

    always_comb begin
        dec     = '0;
        dec.tag = io.in_tag;
        is_i    = (io.in_opcode == OPC_I);
        case (io.in_opcode)
            OPC_R, OPC_I: begin
                dec.imm = is_i;
                case (io.in_funct3)
                    3'b000: dec.op = (io.in_funct7b5 && !is_i) ? OP_SUB : OP_ADD;
                    3'b001: begin
                        dec.op  = OP_SLL;
                        dec.ill = is_i && io.in_funct7b5;
                    end
                    3'b010: dec.op = OP_SLT;
                    3'b011: dec.ill = 1'b1;
                    3'b100: dec.op = OP_XOR;
                    3'b101: dec.op = io.in_funct7b5 ? OP_SRA : OP_SRL;
                    3'b110: dec.op = OP_OR;
                    default: dec.op = OP_AND;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                dec.op  = OP_ADD;
                dec.imm = 1'b1;
            end
            OPC_LUI: begin
                dec.op  = OP_PASSB;
                dec.imm = 1'b1;
            end
            OPC_BR: begin
                case (io.in_funct3)
                    3'b000:  dec.op  = OP_EQ;
                    3'b100:  dec.op  = OP_SLT;
                    default: dec.ill = 1'b1;
                endcase
            end
            default: dec.ill = 1'b1;
        endcase
        // Illegal entries carry a canonical AND/reg payload downstream
        if (dec.ill) begin
            dec.op  = OP_AND;
            dec.imm = 1'b0;
        end
    end

    assign accept  = io.in_valid && !skid_valid_q;
    assign advance = !out_valid_q || io.out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (advance) begin
            if (skid_valid_q) begin
                out_d = skid_q;
            end else if (accept) begin
                out_d = dec;
            end
            out_valid_d = skid_valid_q || accept;
            if (skid_valid_q && accept) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign io.in_ready        = !skid_valid_q;
    assign io.out_valid       = out_valid_q;
    assign io.out_operation   = out_q.op;
    assign io.out_alu_src_imm = out_q.imm;
    assign io.out_illegal     = out_q.ill;
    assign io.out_tag         = out_q.tag;

endmodule

// File: tb/tb_alu_op_issue_stage.sv
// Scoreboard bench for alu_op_issue_stage: directed decode cases,
// back-pressure, flush, async reset, then a randomized phase.
module tb_alu_op_issue_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic        imm;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   pops = 0;
    exp_t sb[$];

    alu_op_issue_stage_if #(.OPCODE_LENGTH(4), .TAG_WIDTH(32)) bus ();

    alu_op_issue_stage #(.OPCODE_LENGTH(4), .TAG_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .io    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference decode written as opcode classes plus a funct3 table.
    function automatic logic [5:0] ref_dec(input logic [6:0] opc,
                                           input logic [2:0] f3,
                                           input logic f7);
        logic [3:0] tbl [8];
        logic [3:0] op;
        logic       imm;
        logic       ill;
        tbl = '{4'b0100, 4'b1001, 4'b1110, 4'b0000,
                4'b0001, 4'b1100, 4'b0011, 4'b0000};
        op  = 4'b0000;
        imm = 1'b0;
        ill = 1'b0;
        if (opc == 7'b0110011 || opc == 7'b0010011) begin
            imm = (opc == 7'b0010011);
            op  = tbl[f3];
            if (f3 == 3'd3) ill = 1'b1;
            if (f3 == 3'd5 && f7) op = 4'b1101;
            if (f3 == 3'd0 && f7 && !imm) op = 4'b0010;
            if (f3 == 3'd1 && f7 && imm) ill = 1'b1;
        end else if (opc == 7'b0000011 || opc == 7'b0100011 ||
                     opc == 7'b1100111) begin
            op  = 4'b0100;
            imm = 1'b1;
        end else if (opc == 7'b0110111) begin
            op  = 4'b1010;
            imm = 1'b1;
        end else if (opc == 7'b1100011) begin
            if (f3 == 3'd0) op = 4'b1000;
            else if (f3 == 3'd4) op = 4'b1110;
            else ill = 1'b1;
        end else begin
            ill = 1'b1;
        end
        if (ill) return 6'b000001;
        return {op, imm, ill};
    endfunction

    // Stimulus side of the scoreboard: record every accepted entry.
    always @(negedge clk) begin
        if (reset || flush) begin
            sb.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            sb.push_back({ref_dec(bus.in_opcode, bus.in_funct3,
                                  bus.in_funct7b5), bus.in_tag});
        end
    end

    exp_t held;
    bit   stall_v = 0;

    // Monitor: pop on each output handshake, check stability on stalls.
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        got = {bus.out_operation, bus.out_alu_src_imm, bus.out_illegal,
               bus.out_tag};
        if (reset || flush) begin
            stall_v = 0;
        end else begin
            if (stall_v) begin
                chk("stall_valid", 64'(bus.out_valid), 64'd1);
                chk("stall_stable", 64'(got), 64'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                stall_v = 0;
                pops++;
                if (sb.size() == 0) begin
                    chk("unexpected_output", 64'(got), 64'd0);
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got tag %h want none",
                             bus.out_tag);
                end else begin
                    want = sb.pop_front();
                    chk("sb_entry", 64'(got), 64'(want));
                end
            end else if (bus.out_valid) begin
                stall_v = 1;
                held    = got;
            end else begin
                stall_v = 0;
            end
        end
    end

    task automatic send(input logic [6:0] opc, input logic [2:0] f3,
                        input logic f7, input logic [31:0] tag);
        bit ok;
        ok              = 0;
        bus.in_valid    = 1'b1;
        bus.in_opcode   = opc;
        bus.in_funct3   = f3;
        bus.in_funct7b5 = f7;
        bus.in_tag      = tag;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready && !flush;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tag %h never accepted", tag);
        end
    endtask

    // Single entry into an empty stage; must appear one cycle later.
    task automatic one(input logic [6:0] opc, input logic [2:0] f3,
                       input logic f7, input logic [31:0] tag,
                       input logic [3:0] eop, input logic eimm,
                       input logic eill, input string nm);
        bus.out_ready = 1'b1;
        send(opc, f3, f7, tag);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk(nm, 64'({bus.out_valid, bus.out_operation, bus.out_alu_src_imm,
                     bus.out_illegal, bus.out_tag}),
            64'({1'b1, eop, eimm, eill, tag}));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk(nm, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [6:0] opcs [10];
        bit         saw_drop;
        int         p0;
        bit         seen;
        opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                 7'b1100111, 7'b0110111, 7'b1100011, 7'b1101111,
                 7'b0010011, 7'b0110011};
        bus.in_valid    = 1'b0;
        bus.in_opcode   = '0;
        bus.in_funct3   = '0;
        bus.in_funct7b5 = 1'b0;
        bus.in_tag      = '0;
        bus.out_ready   = 1'b1;

        #12;
        chk("reset_state", 64'({bus.out_valid, bus.in_ready,
                                bus.out_operation, bus.out_alu_src_imm,
                                bus.out_illegal, bus.out_tag}),
            64'({1'b0, 1'b1, 4'b0, 1'b0, 1'b0, 32'd0}));
        #5 reset = 1'b0;
        @(posedge clk);
        #1;

        one(7'b0110011, 3'b000, 1'b0, 32'h10, 4'b0100, 1'b0, 1'b0, "r_add");
        one(7'b0110011, 3'b000, 1'b1, 32'h14, 4'b0010, 1'b0, 1'b0, "r_sub");
        one(7'b0010011, 3'b101, 1'b1, 32'h20, 4'b1101, 1'b1, 1'b0, "i_srai");
        one(7'b0010011, 3'b101, 1'b0, 32'h24, 4'b1100, 1'b1, 1'b0, "i_srli");
        one(7'b0010011, 3'b001, 1'b1, 32'h28, 4'b0000, 1'b0, 1'b1, "i_slli_bad");
        one(7'b0110111, 3'b011, 1'b0, 32'h50, 4'b1010, 1'b1, 1'b0, "lui");
        one(7'b1100011, 3'b000, 1'b0, 32'h54, 4'b1000, 1'b0, 1'b0, "beq");
        one(7'b1100011, 3'b100, 1'b0, 32'h58, 4'b1110, 1'b0, 1'b0, "blt");
        one(7'b1100011, 3'b001, 1'b0, 32'h5c, 4'b0000, 1'b0, 1'b1, "bne");
        one(7'b1101111, 3'b000, 1'b0, 32'h60, 4'b0000, 1'b0, 1'b1, "jal");
        one(7'b0100011, 3'b010, 1'b0, 32'h64, 4'b0100, 1'b1, 1'b0, "sw");

        // Back-pressure: six back-to-back entries, three stalled cycles.
        saw_drop      = 0;
        p0            = pops;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int t = 1; t <= 6; t++)
                    send(7'b0110011, 3'b000, 1'b0, 32'(t));
                bus.in_valid = 1'b0;
            end
            begin
                seen = 0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = bus.out_valid;
                    if (!bus.in_ready) saw_drop = 1;
                end
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    if (!bus.in_ready) saw_drop = 1;
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        chk("bp_in_ready_drop", 64'(saw_drop), 64'd1);
        chk("bp_count", 64'(pops - p0), 64'd6);

        // Flush with both entries held and a new entry offered.
        bus.out_ready = 1'b0;
        send(7'b0110011, 3'b110, 1'b0, 32'h30);
        send(7'b0110011, 3'b111, 1'b0, 32'h31);
        bus.in_tag = 32'h32;
        flush      = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_state", 64'({bus.out_valid, bus.in_ready}),
            64'({1'b0, 1'b1}));
        @(posedge clk);
        #1;
        one(7'b0000011, 3'b010, 1'b0, 32'h40, 4'b0100, 1'b1, 1'b0,
            "after_flush");

        // Asynchronous reset while stalled with two entries held.
        bus.out_ready = 1'b0;
        send(7'b0110011, 3'b100, 1'b0, 32'h70);
        send(7'b0110011, 3'b001, 1'b0, 32'h71);
        bus.in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("async_reset", 64'({bus.out_valid, bus.in_ready,
                                bus.out_operation, bus.out_tag}),
            64'({1'b0, 1'b1, 4'b0, 32'd0}));
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        one(7'b0100011, 3'b010, 1'b0, 32'h80, 4'b0100, 1'b1, 1'b0,
            "after_reset");

        // Randomized traffic with random stalls and occasional flushes.
        for (int c = 0; c < 600; c++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.in_opcode   = ($urandom_range(0, 9) == 0) ?
                              7'($urandom) : opcs[$urandom_range(0, 9)];
            bus.in_funct3   = 3'($urandom);
            bus.in_funct7b5 = 1'($urandom);
            bus.in_tag      = $urandom;
            bus.out_ready   = ($urandom_range(0, 2) != 0);
            flush           = ($urandom_range(0, 40) == 0);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
